bch_lfsr_codec: RTL and testbench



---
 rtl/bch_lfsr_codec.sv | 188 ++++++++++++++++++
 tb/tb_bch_lfsr_codec.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_lfsr_codec.sv
// Bit-serial LFSR-based systematic BCH codec. It encodes or checks one word at a time.
//
//   ENCODE: divides data(x) * x^R by g(x) and emits {data, parity}.
//   CHECK : divides the received word by g(x) and flags a nonzero remainder.
//
// One bit is processed per clock, MSB first. The block has valid/ready handshakes on its
// input and output sides.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/ready    request handshake; in_mode 0 = ENCODE, 1 = CHECK
//   in_word [N-1:0]   ENCODE: data in [K-1:0]; CHECK: received codeword
//   out_valid/ready   result handshake; out_mode echoes the latched request mode
//   out_codeword      ENCODE: {data, parity}; CHECK: received word unchanged
//   out_remainder     ENCODE: parity; CHECK: syndrome remainder
//   out_error         CHECK with nonzero remainder (always 0 for ENCODE)
//   busy              FSM not idle
//   err_cnt [15:0]    saturating count of failed CHECK words
//
// Optional feature: define BCH_LFSR_ERRCNT_EN to build the error counter.
// Without it, err_cnt is tied to zero.
module bch_lfsr_codec #(
    parameter int unsigned  N        = 31,
    parameter int unsigned  K        = 16,
    parameter logic [N-K:0] GEN_POLY = 16'h8FAF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_mode,
    input  logic [N-1:0]   in_word,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_mode,
    output logic [N-1:0]   out_codeword,
    output logic [N-K-1:0] out_remainder,
    output logic           out_error,
    output logic           busy,
    output logic [15:0]    err_cnt
);

    localparam int unsigned  R  = N - K;
    localparam int unsigned  CW = $clog2(N + 1);
    localparam logic [R-1:0] G  = GEN_POLY[R-1:0];

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e         state_q, state_d;
    logic           mode_q, mode_d;
    logic [N-1:0]   word_q, word_d;
    logic [R-1:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           out_valid_q, out_valid_d;
    logic           out_mode_q, out_mode_d;
    logic [N-1:0]   out_codeword_q, out_codeword_d;
    logic [R-1:0]   out_remainder_q, out_remainder_d;
    logic           out_error_q, out_error_d;

    logic [CW-1:0]  bit_idx;
    logic           cur_bit;
    logic           fb;
    logic           last_bit;
    logic [R-1:0]   rem_step;

    always_comb begin
        // Position of the bit being shifted this cycle. It counts down to 0 on the last bit.
        bit_idx  = (mode_q ? CW'(N - 1) : CW'(K - 1)) - cnt_q;
        cur_bit  = word_q[bit_idx];
        last_bit = (bit_idx == '0);
        fb       = 1'b0;
        rem_step = rem_q << 1;
        if (mode_q) begin
            // Plain division: shift the codeword bit in and reduce by g when the top bit drops out.
            rem_step = rem_step | R'(cur_bit);
            if (rem_q[R-1]) begin
                rem_step = rem_step ^ G;
            end
        end else begin
            // Premultiplied-by-x^R division: the data bit enters at the feedback tap.
            fb = cur_bit ^ rem_q[R-1];
            if (fb) begin
                rem_step = rem_step ^ G;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        word_d          = word_q;
        rem_d           = rem_q;
        cnt_d           = cnt_q;
        out_valid_d     = out_valid_q;
        out_mode_d      = out_mode_q;
        out_codeword_d  = out_codeword_q;
        out_remainder_d = out_remainder_q;
        out_error_d     = out_error_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    word_d  = in_word;
                    mode_d  = in_mode;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                rem_d = rem_step;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d         = StDone;
                    out_valid_d     = 1'b1;
                    out_mode_d      = mode_q;
                    out_remainder_d = rem_step;
                    out_error_d     = mode_q & (|rem_step);
                    out_codeword_d  = mode_q ? word_q : {word_q[K-1:0], rem_step};
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            mode_q          <= 1'b0;
            word_q          <= '0;
            rem_q           <= '0;
            cnt_q           <= '0;
            out_valid_q     <= 1'b0;
            out_mode_q      <= 1'b0;
            out_codeword_q  <= '0;
            out_remainder_q <= '0;
            out_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            word_q          <= word_d;
            rem_q           <= rem_d;
            cnt_q           <= cnt_d;
            out_valid_q     <= out_valid_d;
            out_mode_q      <= out_mode_d;
            out_codeword_q  <= out_codeword_d;
            out_remainder_q <= out_remainder_d;
            out_error_q     <= out_error_d;
        end
    end

`ifdef BCH_LFSR_ERRCNT_EN
    logic [15:0] err_cnt_q;
    logic        err_inc;

    assign err_inc = (state_q == StShift) && last_bit && mode_q && (|rem_step)
                     && (err_cnt_q != 16'hFFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 16'h0000;
        end else if (err_inc) begin
            err_cnt_q <= err_cnt_q + 16'h0001;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'h0000;
`endif

    assign in_ready      = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign out_valid     = out_valid_q;
    assign out_mode      = out_mode_q;
    assign out_codeword  = out_codeword_q;
    assign out_remainder = out_remainder_q;
    assign out_error     = out_error_q;

endmodule

// File: tb/tb_bch_lfsr_codec.sv
// Self-checking bench for bch_lfsr_codec (default N=31, K=16, g = 0x8FAF).
// The reference is GF(2) long division of the whole word by g(x).
module tb_bch_lfsr_codec;

    localparam int unsigned N   = 31;
    localparam int unsigned K   = 16;
    localparam int unsigned R   = N - K;
    localparam logic [63:0] GEN = 64'h8FAF;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_mode;
    logic [N-1:0]   in_word;
    logic           out_valid;
    logic           out_ready;
    logic           out_mode;
    logic [N-1:0]   out_codeword;
    logic [R-1:0]   out_remainder;
    logic           out_error;
    logic           busy;
    logic [15:0]    err_cnt;

    int n_tests;
    int n_fail;
    int exp_errcnt;

    bch_lfsr_codec #(.N(N), .K(K), .GEN_POLY(16'h8FAF)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_codeword(out_codeword), .out_remainder(out_remainder), .out_error(out_error),
        .busy(busy), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of v(x) mod g(x) by schoolbook long division.
    function automatic logic [R-1:0] poly_rem(input logic [63:0] v);
        for (int i = 63; i >= int'(R); i--) begin
            if (v[i]) v = v ^ (GEN << (i - int'(R)));
        end
        return v[R-1:0];
    endfunction

    function automatic logic [N-1:0] enc_model(input logic [K-1:0] d);
        logic [63:0] shifted;
        shifted = 64'(d) << R;
        return {d, poly_rem(shifted)};
    endfunction

    function automatic int errcnt_exp();
`ifdef BCH_LFSR_ERRCNT_EN
        return exp_errcnt;
`else
        return 0;
`endif
    endfunction

    function automatic void note_check(input logic [R-1:0] r);
        if (r != '0 && exp_errcnt != 65535) exp_errcnt++;
    endfunction

    // Drive a request; after acceptance the inputs are scrambled to prove they are ignored.
    task automatic start_word(input logic m, input logic [N-1:0] w);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        in_valid = 1'b1; in_mode = m; in_word = w;
        @(posedge clk); #1;
        in_valid = 1'b0; in_mode = 1'($urandom); in_word = N'($urandom);
    endtask

    // Edges from acceptance until out_valid is seen; -1 if the budget runs out.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_word = '0; out_ready = 1'b0;
        #12;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b busy=%b ready=%b, want 0 0 1",
                     out_valid, busy, in_ready);
        end
        n_tests++;
        if (out_codeword !== '0 || out_remainder !== '0 || out_error !== 1'b0 ||
            out_mode !== 1'b0 || err_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data: cw=%h rem=%h err=%b mode=%b cnt=%h, want all 0",
                     out_codeword, out_remainder, out_error, out_mode, err_cnt);
        end
        exp_errcnt = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic         m   [5];
        logic [N-1:0] w   [5];
        logic [N-1:0] cw  [5];
        logic [R-1:0] rm  [5];
        logic         er  [5];
        int           lat;
        m[0] = 0; w[0] = 31'h00000001; cw[0] = 31'h00008FAF; rm[0] = 15'h0FAF; er[0] = 0;
        m[1] = 0; w[1] = 31'h00000000; cw[1] = 31'h00000000; rm[1] = 15'h0000; er[1] = 0;
        m[2] = 1; w[2] = 31'h00008FAF; cw[2] = 31'h00008FAF; rm[2] = 15'h0000; er[2] = 0;
        m[3] = 1; w[3] = 31'h00008FAE; cw[3] = 31'h00008FAE; rm[3] = 15'h0001; er[3] = 1;
        m[4] = 1; w[4] = 31'h00000FAF; cw[4] = 31'h00000FAF; rm[4] = 15'h0FAF; er[4] = 1;
        for (int i = 0; i < 5; i++) begin
            start_word(m[i], w[i]);
            wait_result(lat);
            if (m[i]) note_check(rm[i]);
            n_tests++;
            if (lat != (m[i] ? int'(N) : int'(K))) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, m[i] ? N : K);
            end
            n_tests++;
            if (out_codeword !== cw[i] || out_remainder !== rm[i] || out_error !== er[i] ||
                out_mode !== m[i]) begin
                n_fail++;
                $display("FAIL dir%0d_result: cw=%h rem=%h err=%b mode=%b want %h %h %b %b",
                         i, out_codeword, out_remainder, out_error, out_mode,
                         cw[i], rm[i], er[i], m[i]);
            end
            n_tests++;
            if (err_cnt !== 16'(errcnt_exp())) begin
                n_fail++;
                $display("FAIL dir%0d_errcnt: got %0d want %0d", i, err_cnt, errcnt_exp());
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [K-1:0] d;
        logic [N-1:0] cw_exp;
        int           lat;
        d = K'($urandom);
        cw_exp = enc_model(d);
        start_word(1'b0, N'(d));
        wait_result(lat);
        n_tests++;
        if (lat != int'(K)) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d want %0d", lat, K);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0]; in_mode = 1'($urandom); in_word = N'($urandom);
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_codeword !== cw_exp ||
                out_remainder !== cw_exp[R-1:0] || out_mode !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b cw=%h rem=%h mode=%b want 1 0 %h %h 0",
                         c, out_valid, in_ready, out_codeword, out_remainder, out_mode,
                         cw_exp, cw_exp[R-1:0]);
            end
        end
        in_valid = 1'b0;
        release_result();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        start_word(1'b0, 31'h00001234);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_errcnt = 0;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_reset: valid=%b busy=%b ready=%b cnt=%h want 0 0 1 0",
                     out_valid, busy, in_ready, err_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        start_word(1'b0, 31'h00000001);
        wait_result(lat);
        n_tests++;
        if (lat != int'(K) || out_codeword !== 31'h00008FAF || out_remainder !== 15'h0FAF) begin
            n_fail++;
            $display("FAIL abort_fresh: lat=%0d cw=%h rem=%h want %0d 00008faf 0faf",
                     lat, out_codeword, out_remainder, K);
        end
        release_result();
    endtask

    task automatic test_random();
        logic [K-1:0] d;
        logic [N-1:0] cw_exp;
        logic [N-1:0] rx;
        logic [R-1:0] rem_exp;
        int           lat;
        int           p;
        for (int i = 0; i < 1000; i++) begin
            d = K'($urandom);
            cw_exp = enc_model(d);
            start_word(1'b0, {$urandom_range(1, 0) == 1 ? {R{1'b1}} : {R{1'b0}}, d});
            wait_result(lat);
            n_tests++;
            if (lat != int'(K) || out_codeword !== cw_exp || out_remainder !== cw_exp[R-1:0] ||
                out_error !== 1'b0 || out_mode !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_enc%0d: lat=%0d cw=%h rem=%h err=%b want %h %h 0",
                         i, lat, out_codeword, out_remainder, out_error, cw_exp, cw_exp[R-1:0]);
            end
            release_result();

            start_word(1'b1, cw_exp);
            wait_result(lat);
            n_tests++;
            if (lat != int'(N) || out_remainder !== '0 || out_error !== 1'b0 ||
                out_codeword !== cw_exp || out_mode !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_chk%0d: lat=%0d cw=%h rem=%h err=%b want %h 0 0",
                         i, lat, out_codeword, out_remainder, out_error, cw_exp);
            end
            release_result();

            if (i % 8 == 0) begin
                p = $urandom_range(N - 1, 0);
                rx = cw_exp ^ (N'(1) << p);
                rem_exp = poly_rem(64'(rx));
                start_word(1'b1, rx);
                wait_result(lat);
                note_check(rem_exp);
                n_tests++;
                if (lat != int'(N) || out_error !== 1'b1 || out_remainder !== rem_exp ||
                    err_cnt !== 16'(errcnt_exp())) begin
                    n_fail++;
                    $display("FAIL rnd_flip%0d: bit=%0d lat=%0d rem=%h err=%b cnt=%0d want %h 1 %0d",
                             i, p, lat, out_remainder, out_error, err_cnt, rem_exp, errcnt_exp());
                end
                release_result();
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        exp_errcnt = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
